// File: rtl/roi_capture_pkg.sv
// Shared ROI geometry, pixel format and capture FSM encoding.
// Used by both the ROI box overlay and the ROI capture reader.
package roi_capture_pkg;

  localparam int unsigned COORD_W    = 11;
  localparam int unsigned RGB565_W   = 16;
  localparam int unsigned CNT_W      = 15;

  localparam int unsigned ROI_X_MIN  = 456;
  localparam int unsigned ROI_Y_MIN  = 328;
  localparam int unsigned ROI_W      = 112;
  localparam int unsigned ROI_H      = 112;
  localparam int unsigned FIFO_DEPTH = 256;

  localparam int unsigned ROI_X_MAX  = ROI_X_MIN + ROI_W - 1;
  localparam int unsigned ROI_Y_MAX  = ROI_Y_MIN + ROI_H - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic                last;
    logic                first;
    logic [RGB565_W-1:0] pix;
  } roi_entry_t;

  localparam int unsigned ENTRY_W = $bits(roi_entry_t);

  function automatic logic in_range(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] lo,
    input logic [COORD_W-1:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/roi_capture_sync_fifo.sv
// First-word-fall-through FIFO with synchronous flush.
// Head entry reads as zero while empty so outputs idle at zero.
module sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_do_push}
                     - {{AW{1'b0}}, w_do_pop};
    end
  end

  // Storage carries no reset; validity is tracked by r_cnt.
  always_ff @(posedge clk) begin
    if (w_do_push && !clr) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/roi_capture.sv
// Captures one frame's ROI pixels into a FIFO on request and
// streams them out over valid/ready with first/last markers.
module roi_capture #(
  parameter int unsigned ROI_X_MIN  = roi_capture_pkg::ROI_X_MIN,
  parameter int unsigned ROI_Y_MIN  = roi_capture_pkg::ROI_Y_MIN,
  parameter int unsigned ROI_W      = roi_capture_pkg::ROI_W,
  parameter int unsigned ROI_H      = roi_capture_pkg::ROI_H,
  parameter int unsigned FIFO_DEPTH = roi_capture_pkg::FIFO_DEPTH
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic [15:0] pixel_in,
  input  logic        pixel_valid_in,
  input  logic        capture_req,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] roi_data,
  output logic        roi_first,
  output logic        roi_last,
  output logic        roi_valid,
  input  logic        roi_ready
);

  import roi_capture_pkg::*;

  localparam logic [COORD_W-1:0] X_LO = COORD_W'(ROI_X_MIN);
  localparam logic [COORD_W-1:0] X_HI = COORD_W'(ROI_X_MIN + ROI_W - 1);
  localparam logic [COORD_W-1:0] Y_LO = COORD_W'(ROI_Y_MIN);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(ROI_Y_MIN + ROI_H - 1);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(ROI_W * ROI_H - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_pix_cnt;
  logic             r_err;
  logic             r_done;

  logic             w_in_roi;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf;
  logic             w_trunc;
  logic             w_flush;
  logic             w_last_push;
  logic             w_req_ok;
  logic             w_full;
  logic             w_empty;
  roi_entry_t       w_din;
  roi_entry_t       w_dout;

  assign w_in_roi = pixel_valid_in
                 && in_range(pixel_x, X_LO, X_HI)
                 && in_range(pixel_y, Y_LO, Y_HI);

  assign w_pop       = !w_empty && roi_ready;
  assign w_push      = (r_state == ST_CAPTURE) && w_in_roi;
  assign w_ovf       = w_push && w_full && !w_pop;
  assign w_trunc     = (r_state == ST_CAPTURE) && frame_start;
  assign w_flush     = w_ovf || w_trunc;
  assign w_last_push = w_push && (r_pix_cnt == LAST_IDX);
  assign w_req_ok    = (r_state == ST_IDLE) && capture_req;

  assign w_din.last  = (r_pix_cnt == LAST_IDX);
  assign w_din.first = (r_pix_cnt == '0);
  assign w_din.pix   = pixel_in;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pixel_clk),
    .rst   (rst),
    .clr   (w_flush),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (capture_req) w_state_nxt = ST_ARMED;
      ST_ARMED:   if (frame_start) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (w_flush)          w_state_nxt = ST_IDLE;
        else if (w_last_push) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN:   if (w_empty) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != ST_IDLE);
    roi_valid = !w_empty;
    roi_data  = w_dout.pix;
    roi_first = w_dout.first;
    roi_last  = w_dout.last;
  end

  assign done = r_done;
  assign err  = r_err;

  // Counter restarts at each armed frame; flushes leave it stale.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && w_empty;
      if (r_state == ST_ARMED && frame_start)
        r_pix_cnt <= '0;
      else if (w_push && !w_flush)
        r_pix_cnt <= r_pix_cnt + 1'b1;
      if (w_req_ok)
        r_err <= 1'b0;
      else if (w_flush)
        r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_roi_capture.sv
// Directed-plus-random bench for roi_capture on a 32x16 frame
// with a 4x3 ROI at (10,5); expectations come from a pixel-list model.
module tb_roi_capture;

  localparam int RX = 10;
  localparam int RY = 5;
  localparam int RW = 4;
  localparam int RH = 3;
  localparam int FW = 32;
  localparam int FH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [15:0] pixel_in;
  logic        pixel_valid_in;
  logic        capture_req;
  logic        capture_req_b;
  logic        roi_ready;
  logic        roi_ready_b;

  logic        busy, done, err, roi_first, roi_last, roi_valid;
  logic [15:0] roi_data;
  logic        busy_b, done_b, err_b, roi_first_b, roi_last_b, roi_valid_b;
  logic [15:0] roi_data_b;

  always #5 clk = ~clk;

  roi_capture #(
    .ROI_X_MIN (RX), .ROI_Y_MIN (RY), .ROI_W (RW), .ROI_H (RH),
    .FIFO_DEPTH (16)
  ) dut (
    .pixel_clk (clk), .rst (rst), .frame_start (frame_start),
    .pixel_x (pixel_x), .pixel_y (pixel_y), .pixel_in (pixel_in),
    .pixel_valid_in (pixel_valid_in), .capture_req (capture_req),
    .busy (busy), .done (done), .err (err), .roi_data (roi_data),
    .roi_first (roi_first), .roi_last (roi_last),
    .roi_valid (roi_valid), .roi_ready (roi_ready)
  );

  roi_capture #(
    .ROI_X_MIN (RX), .ROI_Y_MIN (RY), .ROI_W (RW), .ROI_H (RH),
    .FIFO_DEPTH (8)
  ) dut_b (
    .pixel_clk (clk), .rst (rst), .frame_start (frame_start),
    .pixel_x (pixel_x), .pixel_y (pixel_y), .pixel_in (pixel_in),
    .pixel_valid_in (pixel_valid_in), .capture_req (capture_req_b),
    .busy (busy_b), .done (done_b), .err (err_b), .roi_data (roi_data_b),
    .roi_first (roi_first_b), .roi_last (roi_last_b),
    .roi_valid (roi_valid_b), .roi_ready (roi_ready_b)
  );

  typedef struct {
    logic [15:0] d;
    logic        f;
    logic        l;
  } xfer_t;

  xfer_t exp_q[$];
  int total = 0;
  int bad = 0;
  int n_xfer, n_done, n_done_b, n_last;
  int tick_no = 0;
  int last_pop_tick = 0;
  int rdy_mode = 1;
  logic        stall_prev = 1'b0;
  logic [17:0] stall_val;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] pix(input int x, input int y);
    logic [31:0] xv;
    logic [31:0] yv;
    xv = x;
    yv = y;
    return {yv[4:0], xv[5:0], 5'd0};
  endfunction

  // Reference: ROI pixels seen with valid=1, in raster order.
  task automatic build_exp(input int sx, input int sy, input int last_row);
    int k;
    xfer_t e;
    k = 0;
    exp_q.delete();
    for (int y = 0; y <= last_row; y++)
      for (int x = 0; x < FW; x++)
        if (x >= RX && x < RX + RW && y >= RY && y < RY + RH
            && !(x == sx && y == sy)) begin
          e.d = pix(x, y);
          e.f = (k == 0);
          e.l = (k == RW * RH - 1);
          exp_q.push_back(e);
          k++;
        end
  endtask

  task automatic clr_cnt();
    n_xfer = 0;
    n_done = 0;
    n_done_b = 0;
    n_last = 0;
  endtask

  task automatic tick();
    xfer_t e;
    @(negedge clk);
    tick_no++;
    if (stall_prev) begin
      chk("hold_valid", 32'(roi_valid), 1);
      chk("hold_word", {14'd0, roi_last, roi_first, roi_data},
          {14'd0, stall_val});
    end
    if (roi_valid && roi_ready) begin
      chk("xfer_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("xfer_data", 32'(roi_data), 32'(e.d));
        chk("xfer_first", 32'(roi_first), 32'(e.f));
        chk("xfer_last", 32'(roi_last), 32'(e.l));
      end
      n_xfer++;
      if (roi_last) n_last++;
      last_pop_tick = tick_no;
    end
    stall_prev = roi_valid && !roi_ready;
    stall_val  = {roi_last, roi_first, roi_data};
    if (done) begin
      n_done++;
      chk("done_busy_low", 32'(busy), 0);
      chk("done_latency", 32'(tick_no - last_pop_tick), 2);
    end
    if (done_b) n_done_b++;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic fs, input logic v, input int x, input int y);
    frame_start    = fs;
    pixel_valid_in = v;
    pixel_x        = 11'(x);
    pixel_y        = 11'(y);
    pixel_in       = pix(x, y);
    roi_ready      = (rdy_mode == 2) ? 1'($urandom_range(0, 1))
                                     : (rdy_mode == 1);
    tick();
    frame_start   = 1'b0;
    capture_req   = 1'b0;
    capture_req_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, $urandom_range(0, FW - 1),
                   $urandom_range(0, FH - 1));
  endtask

  // Random invalid cycles with random coordinates are interleaved.
  task automatic send_frame(input int sx, input int sy,
                            input int last_row, input int req_y);
    cyc(1'b1, 1'b0, 0, 0);
    for (int y = 0; y <= last_row; y++)
      for (int x = 0; x < FW; x++) begin
        if ($urandom_range(0, 7) == 0) idle(1);
        if (y == req_y && x == 0) capture_req = 1'b1;
        cyc(1'b0, !(x == sx && y == sy), x, y);
      end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (n_done == 0 && i < budget) begin
      idle(1);
      i++;
    end
    idle(4);
  endtask

  task automatic full_capture(input int mode);
    clr_cnt();
    rdy_mode = mode;
    capture_req = 1'b1;
    idle(1);
    chk("armed_busy", 32'(busy), 1);
    build_exp(-1, -1, FH - 1);
    send_frame(-1, -1, FH - 1, -1);
    drain(300);
    chk("cap_xfers", n_xfer, RW * RH);
    chk("cap_exp_left", exp_q.size(), 0);
    chk("cap_done_cnt", n_done, 1);
    chk("cap_last_cnt", n_last, 1);
    chk("cap_err", 32'(err), 0);
    chk("cap_busy", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    pixel_in = '0;
    pixel_valid_in = 1'b0;
    capture_req = 1'b0;
    capture_req_b = 1'b0;
    roi_ready = 1'b0;
    roi_ready_b = 1'b0;
    clr_cnt();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_valid", 32'(roi_valid), 0);
    chk("rst_word", {14'd0, roi_last, roi_first, roi_data}, 0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Normal capture, consumer always ready.
    full_capture(1);

    // Backpressure: stalled through the whole frame.
    clr_cnt();
    rdy_mode = 0;
    capture_req = 1'b1;
    idle(1);
    build_exp(-1, -1, FH - 1);
    send_frame(-1, -1, FH - 1, -1);
    idle(5);
    chk("bp_valid", 32'(roi_valid), 1);
    chk("bp_head", 32'(roi_data), 32'(pix(RX, RY)));
    chk("bp_first", 32'(roi_first), 1);
    chk("bp_err", 32'(err), 0);
    chk("bp_busy", 32'(busy), 1);
    rdy_mode = 1;
    drain(100);
    chk("bp_xfers", n_xfer, RW * RH);
    chk("bp_done", n_done, 1);
    chk("bp_last", n_last, 1);

    // Overflow on the depth-8 instance.
    clr_cnt();
    capture_req_b = 1'b1;
    idle(1);
    send_frame(-1, -1, RY + 1, -1);
    chk("ovf_pre_err", 32'(err_b), 0);
    chk("ovf_pre_valid", 32'(roi_valid_b), 1);
    chk("ovf_pre_head", 32'(roi_data_b), 32'(pix(RX, RY)));
    chk("ovf_pre_first", 32'(roi_first_b), 1);
    chk("ovf_pre_last", 32'(roi_last_b), 0);
    cyc(1'b0, 1'b1, RX, RY + 2);
    chk("ovf_err", 32'(err_b), 1);
    chk("ovf_valid", 32'(roi_valid_b), 0);
    chk("ovf_busy", 32'(busy_b), 0);
    idle(3);
    chk("ovf_no_done", n_done_b, 0);
    capture_req_b = 1'b1;
    idle(1);
    chk("ovf_req_clr_err", 32'(err_b), 0);
    chk("ovf_rearm_busy", 32'(busy_b), 1);

    // Truncated frame: new frame_start after ROI row 5 only.
    clr_cnt();
    rdy_mode = 0;
    capture_req = 1'b1;
    idle(1);
    exp_q.delete();
    send_frame(-1, -1, RY, -1);
    chk("tr_pre_valid", 32'(roi_valid), 1);
    cyc(1'b1, 1'b0, 0, 0);
    stall_prev = 1'b0;
    chk("tr_err", 32'(err), 1);
    chk("tr_valid", 32'(roi_valid), 0);
    chk("tr_busy", 32'(busy), 0);
    rdy_mode = 1;
    idle(5);
    chk("tr_xfers", n_xfer, 0);
    chk("tr_done", n_done, 0);

    // Invalid pixel (11,6) plus capture_req during CAPTURE.
    clr_cnt();
    rdy_mode = 1;
    capture_req = 1'b1;
    idle(1);
    chk("inv_arm_err", 32'(err), 0);
    build_exp(RX + 1, RY + 1, FH - 1);
    send_frame(RX + 1, RY + 1, FH - 1, RY + 1);
    idle(20);
    chk("inv_xfers", n_xfer, RW * RH - 1);
    chk("inv_exp_left", exp_q.size(), 0);
    chk("inv_last", n_last, 0);
    chk("inv_done", n_done, 0);
    chk("inv_busy", 32'(busy), 1);
    cyc(1'b1, 1'b0, 0, 0);
    chk("inv_trunc_err", 32'(err), 1);
    chk("inv_trunc_busy", 32'(busy), 0);

    // Async reset mid-capture, between clock edges.
    clr_cnt();
    rdy_mode = 2;
    capture_req = 1'b1;
    idle(1);
    build_exp(-1, -1, FH - 1);
    send_frame(-1, -1, RY + 1, -1);
    chk("ar_pre_busy", 32'(busy), 1);
    #3 rst = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_valid", 32'(roi_valid), 0);
    chk("ar_err", 32'(err), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_word", {14'd0, roi_last, roi_first, roi_data}, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    stall_prev = 1'b0;
    full_capture(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
